// File: rtl/pad_ctrl_pkg.sv
// Shared types and defaults for the pad control bank.
// The optional din edge pulses are enabled with PAD_CTRL_EDGE_EN.
package pad_ctrl_pkg;

  typedef enum logic [1:0] {IN, TX_GAP, OUT, RX_GAP} pad_lane_state_e;

  localparam int TURN_CYCLES_DEF = 2;
  localparam int FILT_CYCLES_DEF = 3;

  // Counter width that never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pad_ctrl_lane.sv
// One pad lane: direction sequencer with tri-state turnaround, plus the
// synchronised, glitch-filtered readback path. PAD_CTRL_EDGE_EN adds din edge pulses.
module pad_ctrl_lane
  import pad_ctrl_pkg::*;
#(
  parameter int TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic dir_req,
  input  logic dout,
  input  logic pad_o,
  output logic dir_ack,
  output logic busy,
  output logic pad_oen,
  output logic pad_i,
`ifdef PAD_CTRL_EDGE_EN
  output logic din_rise,
  output logic din_fall,
`endif
  output logic din
);

  localparam int TW = cnt_w(TURN_CYCLES);
  localparam int FW = cnt_w(FILT_CYCLES + 1);

  pad_lane_state_e state, state_nx;
  logic [TW-1:0]   cnt, cnt_nx;
  logic            turn_done;
  logic            oen_nx, ack_nx, busy_nx, pi_nx;

  assign turn_done = (cnt == TW'(TURN_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      IN: if (dir_req) begin
        state_nx = TX_GAP;
        cnt_nx   = '0;
      end
      TX_GAP: begin
        if (!dir_req)       state_nx = IN;
        else if (turn_done) state_nx = OUT;
        else                cnt_nx   = cnt + 1'b1;
      end
      OUT: if (!dir_req) begin
        state_nx = RX_GAP;
        cnt_nx   = '0;
      end
      RX_GAP: begin
        if (turn_done) state_nx = IN;
        else           cnt_nx   = cnt + 1'b1;
      end
      default: state_nx = IN;
    endcase
  end

  // Release is decoded from the live request so OEN rises on the very next edge.
  always_comb begin
    ack_nx  = (state == OUT) && dir_req;
    oen_nx  = !ack_nx;
    busy_nx = (state == TX_GAP) || (state == RX_GAP);
    pi_nx   = ((state == TX_GAP) || ack_nx) && dout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_ack <= 1'b0;
      busy    <= 1'b0;
      pad_oen <= 1'b1;
      pad_i   <= 1'b0;
    end else begin
      dir_ack <= ack_nx;
      busy    <= busy_nx;
      pad_oen <= oen_nx;
      pad_i   <= pi_nx;
    end
  end

  logic [1:0]    sync;
  logic [FW-1:0] fcnt;
  logic          din_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync  <= '0;
      fcnt  <= '0;
      din_q <= 1'b0;
    end else begin
      sync <= {sync[0], pad_o};
      if (sync[1] == din_q) begin
        fcnt <= '0;
      end else if (fcnt == FW'(FILT_CYCLES - 1)) begin
        din_q <= sync[1];
        fcnt  <= '0;
      end else begin
        fcnt <= fcnt + 1'b1;
      end
    end
  end

  // With the filter bypassed the second sync stage is already the registered value.
  assign din = (FILT_CYCLES == 0) ? sync[1] : din_q;

`ifdef PAD_CTRL_EDGE_EN
  logic din_prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      din_prev <= 1'b0;
      din_rise <= 1'b0;
      din_fall <= 1'b0;
    end else begin
      din_prev <= din;
      din_rise <= din & ~din_prev;
      din_fall <= ~din & din_prev;
    end
  end
`endif

endmodule

// File: rtl/pad_ctrl_bank.sv
// Bank of independent pad lanes between the GPIO mux and the pad ring.
// Define PAD_CTRL_EDGE_EN to expose din_rise_o/din_fall_o.
module pad_ctrl_bank
  import pad_ctrl_pkg::*;
#(
  parameter int NUM_PADS    = 8,
  parameter int TURN_CYCLES = TURN_CYCLES_DEF,
  parameter int FILT_CYCLES = FILT_CYCLES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PADS-1:0] dir_req_i,
  input  logic [NUM_PADS-1:0] dout_i,
  output logic [NUM_PADS-1:0] dir_ack_o,
  output logic [NUM_PADS-1:0] busy_o,
  output logic [NUM_PADS-1:0] pad_oen_o,
  output logic [NUM_PADS-1:0] pad_i_o,
  input  logic [NUM_PADS-1:0] pad_o_i,
`ifdef PAD_CTRL_EDGE_EN
  output logic [NUM_PADS-1:0] din_rise_o,
  output logic [NUM_PADS-1:0] din_fall_o,
`endif
  output logic [NUM_PADS-1:0] din_o
);

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_lane
    pad_ctrl_lane #(
      .TURN_CYCLES(TURN_CYCLES),
      .FILT_CYCLES(FILT_CYCLES)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .dir_req (dir_req_i[g]),
      .dout    (dout_i[g]),
      .pad_o   (pad_o_i[g]),
      .dir_ack (dir_ack_o[g]),
      .busy    (busy_o[g]),
      .pad_oen (pad_oen_o[g]),
      .pad_i   (pad_i_o[g]),
`ifdef PAD_CTRL_EDGE_EN
      .din_rise(din_rise_o[g]),
      .din_fall(din_fall_o[g]),
`endif
      .din     (din_o[g])
    );
  end

endmodule

// File: tb/tb_pad_ctrl_bank.sv
// Directed bench for pad_ctrl_bank: expectations are queued per edge and a
// negedge monitor compares them against the outputs.
module tb_pad_ctrl_bank;

  localparam int S_OEN = 0, S_PI = 1, S_ACK = 2, S_BUSY = 3, S_DIN = 4, S_RISE = 5, S_FALL = 6;

  typedef struct {
    int         at;
    int         sig;
    logic [7:0] m;
    logic [7:0] v;
    string      nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] dir_req, dout, pad_o;
  logic [7:0] dir_ack, busy, pad_oen, pad_i, din;
`ifdef PAD_CTRL_EDGE_EN
  logic [7:0] din_rise, din_fall;
`endif

  int   checks = 0;
  int   errors = 0;
  int   edge_n = 0;
  int   k;
  exp_t sb[$];
  exp_t keep[$];

  pad_ctrl_bank #(.NUM_PADS(8), .TURN_CYCLES(2), .FILT_CYCLES(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .dir_req_i (dir_req),
    .dout_i    (dout),
    .dir_ack_o (dir_ack),
    .busy_o    (busy),
    .pad_oen_o (pad_oen),
    .pad_i_o   (pad_i),
    .pad_o_i   (pad_o),
`ifdef PAD_CTRL_EDGE_EN
    .din_rise_o(din_rise),
    .din_fall_o(din_fall),
`endif
    .din_o     (din)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_n <= edge_n + 1;

  function automatic logic [7:0] sig_val(input int s);
    case (s)
      S_OEN:  return pad_oen;
      S_PI:   return pad_i;
      S_ACK:  return dir_ack;
      S_BUSY: return busy;
      S_DIN:  return din;
`ifdef PAD_CTRL_EDGE_EN
      S_RISE: return din_rise;
      S_FALL: return din_fall;
`endif
      default: return 8'hxx;
    endcase
  endfunction

  function automatic void ex(input int at, input int s, input logic [7:0] m,
                             input logic [7:0] v, input string nm);
    sb.push_back('{at, s, m, v, nm});
  endfunction

  // Monitor: outputs are stable at negedge; pop every expectation due for this edge.
  always @(negedge clk) begin
    logic [7:0] act;
    keep = {};
    foreach (sb[i]) begin
      if (sb[i].at == edge_n) begin
        checks++;
        act = sig_val(sb[i].sig);
        if ((act & sb[i].m) !== (sb[i].v & sb[i].m)) begin
          errors++;
          $display("FAIL %s edge %0d: got %b want %b (mask %b)",
                   sb[i].nm, edge_n, act & sb[i].m, sb[i].v & sb[i].m, sb[i].m);
        end
      end else if (sb[i].at < edge_n) begin
        checks++;
        errors++;
        $display("FAIL %s: expectation for edge %0d missed", sb[i].nm, sb[i].at);
      end else begin
        keep.push_back(sb[i]);
      end
    end
    sb = keep;
  end

  task automatic nxt();
    @(negedge clk);
    k = edge_n + 1;
  endtask

  initial begin
    int b, j, r;
    rst = 1'b1; dir_req = '0; dout = '0; pad_o = '0;

    // Reset with random inputs
    for (int c = 0; c < 3; c++) begin
      nxt();
      rst = 1'b1; dir_req = 8'($urandom); dout = 8'($urandom); pad_o = 8'($urandom);
      ex(k, S_OEN,  8'hFF, 8'hFF, "rst_oen");
      ex(k, S_PI,   8'hFF, 8'h00, "rst_pad_i");
      ex(k, S_ACK,  8'hFF, 8'h00, "rst_ack");
      ex(k, S_BUSY, 8'hFF, 8'h00, "rst_busy");
      ex(k, S_DIN,  8'hFF, 8'h00, "rst_din");
    end
    nxt();
    rst = 1'b0; dir_req = '0; dout = '0; pad_o = '0;
    ex(k, S_OEN, 8'hFF, 8'hFF, "idle_oen");
    repeat (3) nxt();

    // Lane 0: turn to output
    nxt(); b = k;
    dir_req[0] = 1'b1; dout[0] = 1'b1;
    ex(b,   S_BUSY, 8'h01, 8'h00, "tx_busy_pre");
    ex(b+1, S_BUSY, 8'h01, 8'h01, "tx_busy1");
    ex(b+2, S_BUSY, 8'h01, 8'h01, "tx_busy2");
    ex(b+3, S_BUSY, 8'h01, 8'h00, "tx_busy_end");
    ex(b+2, S_OEN,  8'h01, 8'h01, "tx_oen_hold");
    ex(b+3, S_OEN,  8'h01, 8'h00, "tx_oen_fall");
    ex(b+2, S_ACK,  8'h01, 8'h00, "tx_ack_pre");
    ex(b+3, S_ACK,  8'h01, 8'h01, "tx_ack");
    ex(b,   S_PI,   8'h01, 8'h00, "tx_pad_i_pre");
    ex(b+1, S_PI,   8'h01, 8'h01, "tx_pad_i");
    repeat (4) nxt();

    // Lane 1: one-cycle request aborts in TX_GAP
    nxt(); b = k;
    dir_req[1] = 1'b1;
    for (int o = 0; o < 5; o++) ex(b+o, S_OEN, 8'h02, 8'h02, "abort_oen");
    ex(b+1, S_BUSY, 8'h02, 8'h02, "abort_busy");
    ex(b+2, S_BUSY, 8'h02, 8'h00, "abort_in");
    ex(b+3, S_ACK,  8'h02, 8'h00, "abort_ack");
    nxt();
    dir_req[1] = 1'b0;
    repeat (5) nxt();

    // Lane 2: reach OUT, release, re-request one cycle later
    nxt(); b = k;
    dir_req[2] = 1'b1;
    ex(b+3, S_OEN, 8'h04, 8'h00, "out2_oen");
    repeat (4) nxt();
    nxt(); j = k;
    dir_req[2] = 1'b0;
    for (int o = 0; o < 6; o++) ex(j+o, S_OEN, 8'h04, 8'h04, "rx_float");
    ex(j+6, S_OEN,  8'h04, 8'h00, "rx_redrive");
    ex(j,   S_ACK,  8'h04, 8'h00, "rx_ack_drop");
    ex(j+1, S_BUSY, 8'h04, 8'h04, "rx_busy1");
    ex(j+2, S_BUSY, 8'h04, 8'h04, "rx_busy2");
    ex(j+3, S_BUSY, 8'h04, 8'h00, "rx_in");
    ex(j+4, S_BUSY, 8'h04, 8'h04, "rx_tx_busy");
    ex(j+6, S_BUSY, 8'h04, 8'h00, "rx_out_busy");
    nxt();
    dir_req[2] = 1'b1;
    repeat (7) nxt();

    // Lane 3: filter, stable rise then fall
    nxt(); b = k;
    pad_o[3] = 1'b1;
    for (int o = 0; o < 4; o++) ex(b+o, S_DIN, 8'h08, 8'h00, "filt_wait_rise");
    ex(b+4, S_DIN, 8'h08, 8'h08, "filt_rise");
`ifdef PAD_CTRL_EDGE_EN
    ex(b+4, S_RISE, 8'h08, 8'h00, "rise_pre");
    ex(b+5, S_RISE, 8'h08, 8'h08, "rise_pulse");
    ex(b+6, S_RISE, 8'h08, 8'h00, "rise_post");
`endif
    repeat (7) nxt();
    nxt(); b = k;
    pad_o[3] = 1'b0;
    ex(b+3, S_DIN, 8'h08, 8'h08, "filt_wait_fall");
    ex(b+4, S_DIN, 8'h08, 8'h00, "filt_fall");
`ifdef PAD_CTRL_EDGE_EN
    ex(b+5, S_FALL, 8'h08, 8'h08, "fall_pulse");
    ex(b+6, S_FALL, 8'h08, 8'h00, "fall_post");
`endif
    repeat (7) nxt();

    // Lane 3: two-sample glitch is rejected
    nxt(); b = k;
    pad_o[3] = 1'b1;
    for (int o = 0; o < 8; o++) ex(b+o, S_DIN, 8'h08, 8'h00, "glitch");
    nxt();
    nxt();
    pad_o[3] = 1'b0;
    repeat (8) nxt();

    // All lanes out, then reset mid-operation
    nxt(); b = k;
    dir_req = 8'hFF; dout = 8'hA5; pad_o[3] = 1'b1;
    ex(b+3, S_OEN, 8'hFF, 8'h00, "all_out_oen");
    ex(b+3, S_ACK, 8'hFF, 8'hFF, "all_out_ack");
    ex(b+4, S_PI,  8'hFF, 8'hA5, "all_out_pad_i");
    ex(b+5, S_DIN, 8'h08, 8'h08, "loop_din");
    repeat (5) nxt();
    nxt(); r = k;
    rst = 1'b1;
    ex(r, S_OEN,  8'hFF, 8'hFF, "mid_rst_oen");
    ex(r, S_ACK,  8'hFF, 8'h00, "mid_rst_ack");
    ex(r, S_BUSY, 8'hFF, 8'h00, "mid_rst_busy");
    ex(r, S_PI,   8'hFF, 8'h00, "mid_rst_pad_i");
    ex(r, S_DIN,  8'hFF, 8'h00, "mid_rst_din");
`ifdef PAD_CTRL_EDGE_EN
    for (int o = 0; o < 3; o++) begin
      ex(r+o, S_RISE, 8'hFF, 8'h00, "rst_no_rise");
      ex(r+o, S_FALL, 8'hFF, 8'h00, "rst_no_fall");
    end
`endif
    nxt();
    rst = 1'b0; dir_req = '0; pad_o = '0;
    ex(r+1, S_OEN, 8'hFF, 8'hFF, "post_rst_oen");
    ex(r+2, S_OEN, 8'hFF, 8'hFF, "post_rst_oen2");
    repeat (5) nxt();

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
